// File: rtl/cap_sense_scanner.sv
// Nine-channel capacitive touch scanner: charges all pads, times each pad's decay,
// thresholds the decay count and debounces the result over consecutive scans.
module cap_sense_scanner #(
    parameter int unsigned CHARGE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned THRESHOLD     = 40,
    parameter int unsigned DEBOUNCE      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] capacitive_sensors_in,
    output logic       capacitive_sensors_out,
    output logic [8:0] touched,
    output logic [8:0] touch_event,
    output logic       scan_done
);

    localparam logic [7:0] CHG_LAST = 8'(CHARGE_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] TO_VAL   = 8'(TIMEOUT);
    localparam logic [7:0] THR      = 8'(THRESHOLD);
    localparam logic [1:0] DEB      = 2'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, EVALUATE} state_t;

    state_t     r_state;
    logic [8:0] r_sync1;
    logic [8:0] r_sync2;
    logic [7:0] r_cnt;
    logic [8:0] r_latched;
    logic [7:0] r_decay [9];
    logic [1:0] r_agree [9];

    logic [8:0] w_hit;
    logic [8:0] w_raw;
    logic [8:0] w_touched_nx;
    logic [8:0] w_rise;
    logic [1:0] w_agree_nx [9];

    // A channel latches in the first MEASURE cycle its synchronized level reads low.
    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            w_hit[i] = (r_state == MEASURE) && !r_latched[i] && !r_sync2[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 9; i++) begin
            w_raw[i]        = (r_decay[i] >= THR);
            w_touched_nx[i] = touched[i];
            w_rise[i]       = 1'b0;
            w_agree_nx[i]   = '0;
            if (w_raw[i] != touched[i]) begin
                if (r_agree[i] + 2'd1 == DEB) begin
                    w_touched_nx[i] = w_raw[i];
                    w_rise[i]       = w_raw[i];
                end else begin
                    w_agree_nx[i] = r_agree[i] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state                <= IDLE;
            r_sync1                <= '0;
            r_sync2                <= '0;
            r_cnt                  <= '0;
            r_latched              <= '0;
            r_decay                <= '{default: '0};
            r_agree                <= '{default: '0};
            capacitive_sensors_out <= 1'b0;
            touched                <= '0;
            touch_event            <= '0;
            scan_done              <= 1'b0;
        end else begin
            r_sync1     <= capacitive_sensors_in;
            r_sync2     <= r_sync1;
            touch_event <= '0;
            scan_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    capacitive_sensors_out <= 1'b0;
                    r_cnt                  <= '0;
                    if (enable) begin
                        r_state                <= CHARGE;
                        capacitive_sensors_out <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (r_cnt == CHG_LAST) begin
                        r_state                <= MEASURE;
                        capacitive_sensors_out <= 1'b0;
                        r_cnt                  <= '0;
                        r_latched              <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                MEASURE: begin
                    for (int unsigned i = 0; i < 9; i++) begin
                        if (w_hit[i]) begin
                            r_decay[i]   <= r_cnt;
                            r_latched[i] <= 1'b1;
                        end else if (!r_latched[i] && r_cnt == TO_LAST) begin
                            r_decay[i]   <= TO_VAL;
                            r_latched[i] <= 1'b1;
                        end
                    end
                    if (((r_latched | w_hit) == '1) || r_cnt == TO_LAST) begin
                        r_state <= EVALUATE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                EVALUATE: begin
                    touched     <= w_touched_nx;
                    r_agree     <= w_agree_nx;
                    touch_event <= w_rise;
                    scan_done   <= 1'b1;
                    r_cnt       <= '0;
                    if (enable) begin
                        r_state                <= CHARGE;
                        capacitive_sensors_out <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
